// File: rtl/v_upd_sched.sv
// Round-robin scheduler sharing the v engine list-update bus between N feed requesters,
// with init hold, busy blocking and a drain/quiesce handshake.

module v_upd_sched_chk #(
   parameter int N = 4
) (
   input logic         clk,
   input logic         rst,
   input logic [N-1:0] req_vld,
   input logic [N-1:0] req_rdy,
   input logic         upd_vld,
   input logic [1:0]   state
);
   a_rdy_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_rdy));
   a_rdy_needs_vld: assert property (@(posedge clk) disable iff (rst) (req_rdy & ~req_vld) == '0);
   a_no_issue_drained: assert property (@(posedge clk) disable iff (rst) !(state == 2'd3 && upd_vld));
endmodule

module v_upd_sched #(
   parameter int N            = 4,
   parameter int ID_W         = 8,
   parameter int CMD_W        = 2,
   parameter int KEY_W        = 16,
   parameter int SIZE_W       = 16,
   parameter int DRAIN_CYCLES = 6,
   parameter int INIT_HOLD    = 2,
   localparam int SRC_W       = (N > 1) ? $clog2(N) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        i_req_vld,
   output logic [N-1:0]        o_req_rdy,
   input  logic [N*ID_W-1:0]   i_req_prod_id,
   input  logic [N*CMD_W-1:0]  i_req_cmd,
   input  logic [N*KEY_W-1:0]  i_req_key,
   input  logic [N*SIZE_W-1:0] i_req_size,
   input  logic                i_busy,
   output logic                o_upd_vld_r,
   output logic [ID_W-1:0]     o_upd_prod_id_r,
   output logic [CMD_W-1:0]    o_upd_cmd_r,
   output logic [KEY_W-1:0]    o_upd_key_r,
   output logic [SIZE_W-1:0]   o_upd_size_r,
   output logic [SRC_W-1:0]    o_upd_src_r,
   input  logic                i_drain_req,
   output logic                o_drained_r,
   output logic [1:0]          o_state_r
);
   localparam int HOLD_W = (INIT_HOLD > 0) ? $clog2(INIT_HOLD + 1) : 1;
   localparam int DRN_W  = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(INIT_HOLD);
   localparam logic [DRN_W-1:0]  DRN_LOAD = DRN_W'(DRAIN_CYCLES);
   localparam logic [N-1:0]      ONE_N    = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      INIT    = 2'd0,
      RUN     = 2'd1,
      DRAIN   = 2'd2,
      DRAINED = 2'd3
   } state_t;

   state_t            state_r;
   logic [SRC_W-1:0]  ptr_r;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [DRN_W-1:0]  drain_cnt_r;

   logic              grant_en_s;
   logic              gnt_vld_s;
   logic              hit_s;
   logic [SRC_W-1:0]  gnt_idx_s;
   logic [SRC_W-1:0]  cand_s;
   logic [SRC_W-1:0]  ptr_nxt_s;

   // Round-robin search from the pointer; drain request outranks any grant.
   always_comb begin
      grant_en_s = (state_r == RUN) && !i_busy && !i_drain_req;
      gnt_vld_s  = 1'b0;
      gnt_idx_s  = '0;
      cand_s     = '0;
      hit_s      = 1'b0;
      for (int i = 0; i < N; i++) begin
         cand_s    = SRC_W'((int'(ptr_r) + i) % N);
         hit_s     = grant_en_s && !gnt_vld_s && i_req_vld[cand_s];
         gnt_idx_s = hit_s ? cand_s : gnt_idx_s;
         gnt_vld_s = gnt_vld_s | hit_s;
      end
      ptr_nxt_s = (gnt_idx_s == SRC_W'(N - 1)) ? '0 : gnt_idx_s + SRC_W'(1);
      o_req_rdy = gnt_vld_s ? (ONE_N << gnt_idx_s) : '0;
   end

   // Control FSM: init hold, run/arbitrate, drain countdown, drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= INIT;
         ptr_r       <= '0;
         hold_cnt_r  <= '0;
         drain_cnt_r <= '0;
         o_drained_r <= 1'b0;
      end else begin
         case (state_r)
            INIT: begin
               if (hold_cnt_r != HOLD_MAX) begin
                  hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
               end
               if (hold_cnt_r == HOLD_MAX && !i_busy) begin
                  state_r <= RUN;
               end
            end
            RUN: begin
               if (i_drain_req) begin
                  state_r     <= DRAIN;
                  drain_cnt_r <= DRN_LOAD;
               end else if (gnt_vld_s) begin
                  ptr_r <= ptr_nxt_s;
               end
            end
            DRAIN: begin
               if (!i_drain_req) begin
                  state_r     <= RUN;
                  drain_cnt_r <= '0;
               end else if (drain_cnt_r == '0) begin
                  state_r     <= DRAINED;
                  o_drained_r <= 1'b1;
               end else begin
                  drain_cnt_r <= drain_cnt_r - DRN_W'(1);
               end
            end
            DRAINED: begin
               if (!i_drain_req) begin
                  state_r     <= RUN;
                  o_drained_r <= 1'b0;
               end
            end
            default: begin
               state_r     <= INIT;
               o_drained_r <= 1'b0;
            end
         endcase
      end
   end

   // Issue register: fields captured only on the handshake cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_upd_vld_r     <= 1'b0;
         o_upd_prod_id_r <= '0;
         o_upd_cmd_r     <= '0;
         o_upd_key_r     <= '0;
         o_upd_size_r    <= '0;
         o_upd_src_r     <= '0;
      end else begin
         o_upd_vld_r <= gnt_vld_s;
         if (gnt_vld_s) begin
            o_upd_prod_id_r <= i_req_prod_id[gnt_idx_s*ID_W +: ID_W];
            o_upd_cmd_r     <= i_req_cmd[gnt_idx_s*CMD_W +: CMD_W];
            o_upd_key_r     <= i_req_key[gnt_idx_s*KEY_W +: KEY_W];
            o_upd_size_r    <= i_req_size[gnt_idx_s*SIZE_W +: SIZE_W];
            o_upd_src_r     <= gnt_idx_s;
         end
      end
   end

   assign o_state_r = state_r;

   v_upd_sched_chk #(.N(N)) u_chk (
      .clk     (clk),
      .rst     (rst),
      .req_vld (i_req_vld),
      .req_rdy (o_req_rdy),
      .upd_vld (o_upd_vld_r),
      .state   (o_state_r)
   );
endmodule

// File: tb/tb_v_upd_sched.sv
// Directed, table-driven bench for v_upd_sched (N=4, default parameters).

module tb_v_upd_sched;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  vld;
   logic [3:0]  rdy;
   logic [31:0] prod_id;
   logic [7:0]  cmd;
   logic [63:0] key;
   logic [63:0] size;
   logic        busy;
   logic        uv;
   logic [7:0]  up_prod;
   logic [1:0]  up_cmd;
   logic [15:0] up_key;
   logic [15:0] up_size;
   logic [1:0]  up_src;
   logic        drain;
   logic        drained;
   logic [1:0]  state;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] vld;
      logic       busy;
      logic       drain;
      logic [3:0] rdy;
      logic       uv;
      logic [7:0] prod;
      logic [1:0] src;
   } vec_t;

   vec_t tbl [16];

   always #5 clk = ~clk;

   v_upd_sched dut (
      .clk             (clk),
      .rst             (rst),
      .i_req_vld       (vld),
      .o_req_rdy       (rdy),
      .i_req_prod_id   (prod_id),
      .i_req_cmd       (cmd),
      .i_req_key       (key),
      .i_req_size      (size),
      .i_busy          (busy),
      .o_upd_vld_r     (uv),
      .o_upd_prod_id_r (up_prod),
      .o_upd_cmd_r     (up_cmd),
      .o_upd_key_r     (up_key),
      .o_upd_size_r    (up_size),
      .o_upd_src_r     (up_src),
      .i_drain_req     (drain),
      .o_drained_r     (drained),
      .o_state_r       (state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      prod_id = {8'h13, 8'h12, 8'h11, 8'h10};
      cmd     = {2'd3, 2'd2, 2'd1, 2'd0};
      key     = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      size    = {16'h0203, 16'h0202, 16'h0201, 16'h0200};

      //          vld    busy  drain rdy      uv    prod   src
      tbl[0]  = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0};
      tbl[1]  = '{4'hF, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0};
      tbl[2]  = '{4'hF, 1'b0, 1'b0, 4'b0010, 1'b1, 8'h11, 2'd1};
      tbl[3]  = '{4'hF, 1'b0, 1'b0, 4'b0100, 1'b1, 8'h12, 2'd2};
      tbl[4]  = '{4'hF, 1'b0, 1'b0, 4'b1000, 1'b1, 8'h13, 2'd3};
      tbl[5]  = '{4'hF, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0};
      tbl[6]  = '{4'h5, 1'b0, 1'b0, 4'b0100, 1'b1, 8'h12, 2'd2};
      tbl[7]  = '{4'h5, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0};
      tbl[8]  = '{4'h5, 1'b0, 1'b0, 4'b0100, 1'b1, 8'h12, 2'd2};
      tbl[9]  = '{4'hF, 1'b0, 1'b0, 4'b1000, 1'b1, 8'h13, 2'd3};
      tbl[10] = '{4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h13, 2'd3};
      tbl[11] = '{4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h13, 2'd3};
      tbl[12] = '{4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h13, 2'd3};
      tbl[13] = '{4'hF, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0};
      tbl[14] = '{4'hF, 1'b0, 1'b0, 4'b0010, 1'b1, 8'h11, 2'd1};
      tbl[15] = '{4'hF, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};

      rst = 1'b1; busy = 1'b1; drain = 1'b0; vld = 4'hF;
      repeat (3) tick();
      check("rst_state", 32'(state), 32'd0);
      check("rst_upd_vld", 32'(uv), 32'd0);
      check("rst_drained", 32'(drained), 32'd0);
      check("rst_src", 32'(up_src), 32'd0);
      check("rst_prod", 32'(up_prod), 32'd0);
      check("rst_rdy", 32'(rdy), 32'd0);

      // Busy held through the init hold: nothing may be granted.
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("init_busy_rdy", 32'(rdy), 32'd0);
         tick();
         check("init_busy_state", 32'(state), 32'd0);
      end

      for (int i = 0; i < 16; i++) begin
         vld = tbl[i].vld; busy = tbl[i].busy; drain = tbl[i].drain;
         #1;
         check($sformatf("v%0d_rdy", i), 32'(rdy), 32'(tbl[i].rdy));
         tick();
         check($sformatf("v%0d_upd_vld", i), 32'(uv), 32'(tbl[i].uv));
         check($sformatf("v%0d_prod", i), 32'(up_prod), 32'(tbl[i].prod));
         check($sformatf("v%0d_src", i), 32'(up_src), 32'(tbl[i].src));
         if (tbl[i].uv) begin
            check($sformatf("v%0d_key", i), 32'(up_key), 32'h1000 + 32'(tbl[i].src));
            check($sformatf("v%0d_size", i), 32'(up_size), 32'h0200 + 32'(tbl[i].src));
            check($sformatf("v%0d_cmd", i), 32'(up_cmd), 32'(tbl[i].src));
         end
      end

      // Drain held: drained appears DRAIN_CYCLES+1 edges after the load edge.
      for (int i = 1; i <= 9; i++) begin
         #1;
         check("drain_rdy", 32'(rdy), 32'd0);
         tick();
         check($sformatf("drain_e%0d_drained", i), 32'(drained), (i >= 7) ? 32'd1 : 32'd0);
         check($sformatf("drain_e%0d_state", i), 32'(state), (i >= 7) ? 32'd3 : 32'd2);
         check("drain_upd_vld", 32'(uv), 32'd0);
      end
      drain = 1'b0;
      #1;
      check("drained_exit_rdy", 32'(rdy), 32'd0);
      tick();
      check("drained_exit_state", 32'(state), 32'd1);
      check("drained_exit_flag", 32'(drained), 32'd0);
      #1;
      check("resume_rdy", 32'(rdy), 32'b0100);
      tick();
      check("resume_upd_vld", 32'(uv), 32'd1);
      check("resume_prod", 32'(up_prod), 32'h12);
      check("resume_src", 32'(up_src), 32'd2);

      // Short drain aborted before the counter expires.
      drain = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("abort_rdy", 32'(rdy), 32'd0);
         tick();
         check("abort_drained", 32'(drained), 32'd0);
         check("abort_state", 32'(state), 32'd2);
      end
      drain = 1'b0;
      #1;
      check("abort_exit_rdy", 32'(rdy), 32'd0);
      tick();
      check("abort_exit_state", 32'(state), 32'd1);
      check("abort_exit_drained", 32'(drained), 32'd0);
      #1;
      check("abort_resume_rdy", 32'(rdy), 32'b1000);
      tick();
      check("abort_resume_prod", 32'(up_prod), 32'h13);
      check("abort_resume_src", 32'(up_src), 32'd3);

      // Reach DRAINED, then reset.
      drain = 1'b1;
      repeat (9) tick();
      check("pre_rst_state", 32'(state), 32'd3);
      check("pre_rst_drained", 32'(drained), 32'd1);
      rst = 1'b1;
      tick();
      check("rst_drained_state", 32'(state), 32'd0);
      check("rst_drained_flag", 32'(drained), 32'd0);
      check("rst_drained_prod", 32'(up_prod), 32'd0);
      check("rst_drained_src", 32'(up_src), 32'd0);
      check("rst_drained_rdy", 32'(rdy), 32'd0);

      // Reset while an issue is in flight drops it.
      rst = 1'b0; drain = 1'b0; busy = 1'b0;
      repeat (3) tick();
      check("reinit_state", 32'(state), 32'd1);
      #1;
      check("reinit_rdy", 32'(rdy), 32'b0001);
      tick();
      check("reinit_upd_vld", 32'(uv), 32'd1);
      check("reinit_prod", 32'(up_prod), 32'h10);
      rst = 1'b1;
      tick();
      check("rst_issue_upd_vld", 32'(uv), 32'd0);
      check("rst_issue_prod", 32'(up_prod), 32'd0);
      check("rst_issue_state", 32'(state), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
